// File: rtl/pi_sample_tx_if.sv
// SPI link between the Raspberry Pi (master) and the sample transmitter (slave).
interface pi_sample_tx_if;
  logic sck;
  logic csN;
  logic miso;

  modport master (output sck, output csN, input miso);
  modport slave  (input sck, input csN, output miso);
endinterface

// File: rtl/pi_sample_tx.sv
// SPI-slave transmitter: latches one processed sample per round and shifts it
// to the Pi as a 16-bit mode-0 frame {fresh, seq[3:0], sample[10:0]}.
// Stale frames (fresh=0) and overwritten samples (dropCount) let the Pi detect
// a rate mismatch between its reads and the sample rounds.
module pi_sample_tx #(
  parameter logic [9:0] LATCH_CYCLE = 10'h6,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        counter,
  input  logic [10:0]       sendVoltage,
  pi_sample_tx_if.slave     spi,
  output logic              frameDone,
  output logic [7:0]        dropCount
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_WAIT} state_t;

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   sckRise;
  logic                   sckFall;
  logic                   csFall;
  logic                   csRise;

  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bitCount;
  logic        miso_q;
  logic        armed;
  logic [10:0] hold;
  logic [3:0]  seq;
  logic        valid;
  logic        capture;
  logic        load;

  // --- input synchronizers and edge detect ---
  // cs sync resets low so reset never fakes a "csN high" observation (armed)
  // or a csFall; a csN already high simply arms a few clocks later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi.csN};
      sck_d    <= sck_sync[SYNC_STAGES-1];
      cs_d     <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign sckRise = sck_s & ~sck_d;
  assign sckFall = ~sck_s & sck_d;
  assign csFall  = ~cs_s & cs_d;
  assign csRise  = cs_s & ~cs_d;

  assign capture = (counter == LATCH_CYCLE);
  assign load    = (state == S_IDLE) && csFall && armed;

  // --- sample capture, frame load and SPI shift state machine ---
  // A capture coinciding with a load hands the old sample to the frame, so
  // that case is not an overwrite and does not count as a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitCount  <= '0;
      miso_q    <= 1'b0;
      frameDone <= 1'b0;
      dropCount <= '0;
      armed     <= 1'b0;
      hold      <= '0;
      seq       <= '0;
      valid     <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (cs_s) armed <= 1'b1;

      if (capture) begin
        hold <= sendVoltage;
        seq  <= seq + 4'd1;
        if (valid && !load) dropCount <= sat_inc8(dropCount);
      end

      if (capture)   valid <= 1'b1;
      else if (load) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          miso_q <= 1'b0;
          if (load) begin
            shreg    <= {valid, seq, hold};
            miso_q   <= valid;
            bitCount <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (csRise) begin
            miso_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            if (sckRise) begin
              bitCount <= bitCount + 5'd1;
              if (bitCount == 5'd15) state <= S_DONE;
            end
            if (sckFall) begin
              shreg  <= {shreg[14:0], 1'b0};
              miso_q <= shreg[14];
            end
          end
        end
        S_DONE: begin
          frameDone <= 1'b1;
          miso_q    <= 1'b0;
          // csN may already be back high by the time DONE is reached.
          state     <= csRise ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          miso_q <= 1'b0;
          if (csRise) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign spi.miso = miso_q;

endmodule

// File: tb/tb_pi_sample_tx.sv
// Bench for pi_sample_tx: a Pi-side mode-0 SPI master at 1 MHz, a reference
// model of hold/seq/valid/dropCount, and a queue of expected frames.
`timescale 1ns/1ps
module tb_pi_sample_tx;

  localparam logic [9:0] LATCH = 10'h6;
  localparam int         SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter;
  logic [10:0] sendVoltage;
  logic        frameDone;
  logic [7:0]  dropCount;

  pi_sample_tx_if spi ();

  pi_sample_tx #(.LATCH_CYCLE(LATCH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .counter    (counter),
    .sendVoltage(sendVoltage),
    .spi        (spi.slave),
    .frameDone  (frameDone),
    .dropCount  (dropCount)
  );

  always #12.5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  // reference model state
  logic [10:0] m_hold;
  logic [3:0]  m_seq;
  logic        m_valid;
  logic [7:0]  m_drop;
  logic [15:0] sb[$];

  always @(negedge clk) if (frameDone === 1'b1) done_cnt++;

  task automatic model_reset();
    m_hold = '0; m_seq = '0; m_valid = 1'b0; m_drop = '0;
    sb.delete();
  endtask

  task automatic model_capture(input logic [10:0] v);
    if (m_valid) m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
    m_hold = v; m_seq = m_seq + 4'd1; m_valid = 1'b1;
  endtask

  task automatic model_load();
    sb.push_back({m_valid, m_seq, m_hold});
    m_valid = 1'b0;
  endtask

  task automatic capture(input logic [10:0] v);
    @(negedge clk);
    sendVoltage = v;
    counter = LATCH;
    @(negedge clk);
    counter = '0;
    model_capture(v);
  endtask

  // Clocks `rises` bits with csN already low; samples miso at each rise.
  task automatic spi_bits(input int rises, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < rises; i++) begin
      got = {got[14:0], spi.miso};
      spi.sck = 1'b1; #500;
      spi.sck = 1'b0; #500;
    end
    spi.csN = 1'b1; #500;
  endtask

  task automatic spi_frame(input int rises, output logic [15:0] got);
    @(negedge clk);
    spi.csN = 1'b0; #500;
    spi_bits(rises, got);
  endtask

  // Pops the next expected frame; an empty queue is itself a failure.
  task automatic pop_exp(output logic [15:0] e);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty got=0 required=1 entries");
      e = 'x;
    end else e = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1; counter = '0; sendVoltage = '0;
    spi.sck = 1'b0; spi.csN = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    total++; if (spi.miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b required=0", spi.miso); end
    total++; if (frameDone !== 1'b0) begin bad++; $display("FAIL rst_frameDone got=%b required=0", frameDone); end
    total++; if (dropCount !== 8'h00) begin bad++; $display("FAIL rst_dropCount got=%h required=00", dropCount); end
    reset = 1'b0;
    #500;
  endtask

  task automatic test_basic_frame();
    logic [15:0] got, e;
    int d0;
    capture(11'h5A3);
    d0 = done_cnt;
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL basic_frame got=%h required=%h", got, e); end
    total++; if (got !== 16'h8DA3) begin bad++; $display("FAIL basic_const got=%h required=8da3", got); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done got=%0d required=1", done_cnt - d0); end
    total++; if (dropCount !== 8'h00) begin bad++; $display("FAIL basic_drop got=%h required=00", dropCount); end
    total++; if (spi.miso !== 1'b0) begin bad++; $display("FAIL idle_miso got=%b required=0", spi.miso); end
  endtask

  task automatic test_stale();
    logic [15:0] got, e;
    int d0;
    d0 = done_cnt;
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL stale_frame got=%h required=%h", got, e); end
    total++; if (got !== 16'h0DA3) begin bad++; $display("FAIL stale_const got=%h required=0da3", got); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL stale_done got=%0d required=1", done_cnt - d0); end
  endtask

  task automatic test_drop();
    logic [15:0] got, e;
    capture(11'h001);
    capture(11'h002);
    capture(11'h403);
    total++; if (dropCount !== 8'd2) begin bad++; $display("FAIL drop_count got=%0d required=2", dropCount); end
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL drop_frame got=%h required=%h", got, e); end
    for (int i = 0; i < 300; i++) capture(11'(i));
    total++; if (dropCount !== 8'hFF) begin bad++; $display("FAIL drop_sat got=%h required=ff", dropCount); end
    total++; if (dropCount !== m_drop) begin bad++; $display("FAIL drop_model got=%h required=%h", dropCount, m_drop); end
  endtask

  task automatic test_abort();
    logic [15:0] got, e;
    int d0;
    d0 = done_cnt;
    model_load();
    spi_frame(7, got);
    pop_exp(e);
    total++; if (got[6:0] !== e[15:9]) begin bad++; $display("FAIL abort_bits got=%h required=%h", got[6:0], e[15:9]); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_done got=%0d required=%0d", done_cnt, d0); end
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL abort_next got=%h required=%h", got, e); end
    total++; if (got[15] !== 1'b0) begin bad++; $display("FAIL abort_fresh got=%b required=0", got[15]); end
    capture(11'h2C5);
    d0 = done_cnt;
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL abort_intact got=%h required=%h", got, e); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_intact_done got=%0d required=1", done_cnt - d0); end
  endtask

  task automatic test_collision_wrap();
    logic [15:0] got, e;
    logic [3:0] seq0;
    capture(11'h123);
    // csN fall timed so its synchronized edge meets counter==LATCH on one clk
    @(negedge clk);
    spi.csN = 1'b0;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    sendVoltage = 11'h2BC;
    counter = LATCH;
    model_load();
    model_capture(11'h2BC);
    @(negedge clk);
    counter = '0;
    #(500 - 25 * (SYNC + 1));
    spi_bits(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL coll_old got=%h required=%h", got, e); end
    total++; if (got[10:0] !== 11'h123) begin bad++; $display("FAIL coll_old_data got=%h required=123", got[10:0]); end
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL coll_new got=%h required=%h", got, e); end
    total++; if (got[15] !== 1'b1 || got[10:0] !== 11'h2BC) begin bad++; $display("FAIL coll_new_data got=%h required=1/2bc", got); end
    seq0 = m_seq;
    for (int i = 0; i < 16; i++) capture(11'h600 + 11'(i));
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL wrap_frame got=%h required=%h", got, e); end
    total++; if (got[14:11] !== seq0) begin bad++; $display("FAIL wrap_seq got=%h required=%h", got[14:11], seq0); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got, e;
    int d0;
    capture(11'h0F0);
    model_load();
    @(negedge clk);
    spi.csN = 1'b0; #500;
    for (int i = 0; i < 5; i++) begin
      spi.sck = 1'b1; #500;
      spi.sck = 1'b0; #500;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (spi.miso !== 1'b0) begin bad++; $display("FAIL mid_rst_miso got=%b required=0", spi.miso); end
    reset = 1'b0;
    model_reset();
    d0 = done_cnt;
    for (int i = 0; i < 11; i++) begin
      spi.sck = 1'b1; #500;
      total++; if (spi.miso !== 1'b0) begin bad++; $display("FAIL mid_miso bit=%0d got=%b required=0", i, spi.miso); end
      spi.sck = 1'b0; #500;
    end
    spi.csN = 1'b1; #500;
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL mid_done got=%0d required=%0d", done_cnt, d0); end
    total++; if (dropCount !== 8'h00) begin bad++; $display("FAIL mid_drop got=%h required=00", dropCount); end
    capture(11'h7FF);
    d0 = done_cnt;
    model_load();
    spi_frame(16, got);
    pop_exp(e);
    total++; if (got !== e) begin bad++; $display("FAIL mid_next got=%h required=%h", got, e); end
    total++; if (got !== 16'h8FFF) begin bad++; $display("FAIL mid_next_const got=%h required=8fff", got); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL mid_next_done got=%0d required=1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stale();
    test_drop();
    test_abort();
    test_collision_wrap();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
